// File: rtl/hazard_stall_controller.sv
// ID-stage hazard scheduler: load-use and branch-operand stall sequencing
// with saturating stall/flush performance counters.
module hazard_stall_controller #(
  parameter int unsigned LOAD_USE_STALLS    = 1,
  parameter int unsigned ALU_BRANCH_STALLS  = 1,
  parameter int unsigned LOAD_BRANCH_STALLS = 2,
  parameter int unsigned LOAD_MEM_BR_STALLS = 1,
  parameter int unsigned CNT_W              = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_rd,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_rd,
  input  logic             IF_Flush,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Flush,
  output logic             Hazard,
  output logic             StallState,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [2:0] LU  = 3'(LOAD_USE_STALLS);
  localparam logic [2:0] AB  = 3'(ALU_BRANCH_STALLS);
  localparam logic [2:0] LB  = 3'(LOAD_BRANCH_STALLS);
  localparam logic [2:0] LMB = 3'(LOAD_MEM_BR_STALLS);

  typedef enum logic {
    RUN,
    STALL
  } state_e;

  state_e state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic [2:0] n_req;
  logic       ex_hit;
  logic       mem_hit;
  logic       hazard;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // $0 is hardwired zero, so it never carries a dependency
  assign ex_hit = (EX_rd != 5'd0) &&
                  ((EX_rd == ID_rs) ||
                   (ID_UsesRt && (EX_rd == ID_rt)));

  assign mem_hit = (MEM_rd != 5'd0) &&
                   ((MEM_rd == ID_rs) ||
                    (ID_UsesRt && (MEM_rd == ID_rt)));

  always_comb begin
    n_req = 3'd0;
    if (!ID_Branch && EX_MemRead && ex_hit
        && (LU > n_req))
      n_req = LU;
    if (ID_Branch && EX_MemRead && ex_hit
        && (LB > n_req))
      n_req = LB;
    if (ID_Branch && EX_RegWrite && !EX_MemRead
        && ex_hit && (AB > n_req))
      n_req = AB;
    if (ID_Branch && MEM_MemRead && mem_hit
        && (LMB > n_req))
      n_req = LMB;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    hazard  = 1'b0;
    if (reset) begin
      state_d = RUN;
      rem_d   = 3'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (n_req != 3'd0) begin
            hazard = 1'b1;
            if (n_req > 3'd1) begin
              rem_d   = n_req - 3'd1;
              state_d = STALL;
            end
          end
        end
        STALL: begin
          hazard = 1'b1;
          rem_d  = rem_q - 3'd1;
          if (rem_q <= 3'd1) begin
            rem_d   = 3'd0;
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      rem_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Flushes during a stall are suppressed downstream, so not counted
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (IF_Flush && !hazard
          && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign Hazard      = hazard;
  assign PC_Write    = !hazard;
  assign IF_ID_Write = !hazard;
  assign ID_EX_Flush = hazard;
  assign StallState  = !reset && (state_q == STALL);
  assign StallCount  = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: directed vectors,
// expectations queued by stimulus, popped mid-cycle by a monitor.
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] ID_rs, ID_rt, EX_rd, MEM_rd;
  logic ID_UsesRt, ID_Branch, EX_MemRead, EX_RegWrite;
  logic MEM_MemRead, IF_Flush;

  logic pcw, idw, exf, hz, st;
  logic [31:0] sc, fc;
  logic pcw4, idw4, exf4, hz4, st4;
  logic [3:0] sc4, fc4;

  always #5 clk = ~clk;

  hazard_stall_controller dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
    .EX_rd(EX_rd), .MEM_MemRead(MEM_MemRead),
    .MEM_rd(MEM_rd), .IF_Flush(IF_Flush),
    .PC_Write(pcw), .IF_ID_Write(idw),
    .ID_EX_Flush(exf), .Hazard(hz),
    .StallState(st), .StallCount(sc),
    .FlushCount(fc)
  );

  hazard_stall_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
    .EX_rd(EX_rd), .MEM_MemRead(MEM_MemRead),
    .MEM_rd(MEM_rd), .IF_Flush(IF_Flush),
    .PC_Write(pcw4), .IF_ID_Write(idw4),
    .ID_EX_Flush(exf4), .Hazard(hz4),
    .StallState(st4), .StallCount(sc4),
    .FlushCount(fc4)
  );

  typedef struct {
    int          id;
    logic        hz;
    logic        st;
    logic [31:0] sc;
    logic [31:0] fc;
    logic [3:0]  sc4;
    logic [3:0]  fc4;
  } exp_t;

  exp_t q[$];
  int nvec = 0;
  int nerr = 0;
  int vid  = 0;

  logic [31:0] e_sc, e_fc;
  logic [3:0]  e_sc4, e_fc4;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act,
                     input logic [31:0] req);
    if (act !== req) begin
      nerr++;
      $display("FAIL vec%0d %s: got %0h want %0h",
               id, nm, act, req);
    end
  endtask

  // Monitor: outputs are combinational, sampled mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      nvec++;
      chk("Hazard", e.id, 32'(hz), 32'(e.hz));
      chk("PC_Write", e.id, 32'(pcw), 32'(!e.hz));
      chk("IF_ID_Write", e.id, 32'(idw), 32'(!e.hz));
      chk("ID_EX_Flush", e.id, 32'(exf), 32'(e.hz));
      chk("StallState", e.id, 32'(st), 32'(e.st));
      chk("StallCount", e.id, sc, e.sc);
      chk("FlushCount", e.id, fc, e.fc);
      chk("Hazard4", e.id, 32'(hz4), 32'(e.hz));
      chk("StallState4", e.id, 32'(st4), 32'(e.st));
      chk("StallCount4", e.id, 32'(sc4), 32'(e.sc4));
      chk("FlushCount4", e.id, 32'(fc4), 32'(e.fc4));
    end
  end

  // One cycle: queue the expectation, then advance counter model
  task automatic cyc(input logic ehz, input logic est);
    exp_t e;
    e.id  = vid;
    e.hz  = ehz;
    e.st  = est;
    e.sc  = e_sc;
    e.fc  = e_fc;
    e.sc4 = e_sc4;
    e.fc4 = e_fc4;
    q.push_back(e);
    vid++;
    if (reset) begin
      e_sc = '0; e_fc = '0; e_sc4 = '0; e_fc4 = '0;
    end else begin
      if (ehz) begin
        if (e_sc != '1) e_sc = e_sc + 1;
        if (e_sc4 != '1) e_sc4 = e_sc4 + 1;
      end else if (IF_Flush) begin
        if (e_fc != '1) e_fc = e_fc + 1;
        if (e_fc4 != '1) e_fc4 = e_fc4 + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_rs = 0; ID_rt = 0; ID_UsesRt = 0;
    ID_Branch = 0; EX_MemRead = 0;
    EX_RegWrite = 0; EX_rd = 0;
    MEM_MemRead = 0; MEM_rd = 0;
    IF_Flush = 0;
  endtask

  task automatic ld_br();
    idle();
    EX_MemRead = 1; EX_rd = 8;
    ID_Branch = 1; ID_rs = 8;
  endtask

  initial begin
    idle();
    reset = 1;
    e_sc = '0; e_fc = '0; e_sc4 = '0; e_fc4 = '0;
    @(posedge clk);
    #1;
    // reset held with a live hazard: outputs forced idle
    ld_br();
    cyc(0, 0);
    reset = 0;
    idle();
    cyc(0, 0);

    // load-use, non-branch: one Mealy stall
    EX_MemRead = 1; EX_rd = 8; ID_rs = 8;
    cyc(1, 0);
    idle();
    cyc(0, 0);

    // load feeding a branch: two stalls, inputs ignored in 2nd
    ld_br();
    cyc(1, 0);
    idle();
    cyc(1, 1);
    cyc(0, 0);

    // $0 never hazards; rt only counts when used
    EX_MemRead = 1; EX_rd = 0; ID_rs = 0;
    cyc(0, 0);
    EX_rd = 9; ID_rt = 9; ID_rs = 3; ID_UsesRt = 0;
    cyc(0, 0);
    ID_UsesRt = 1;
    cyc(1, 0);
    idle();
    cyc(0, 0);

    // ALU result feeding a branch
    EX_RegWrite = 1; EX_rd = 5;
    ID_Branch = 1; ID_rt = 5; ID_UsesRt = 1;
    cyc(1, 0);
    ID_Branch = 0;
    cyc(0, 0);
    idle();
    // load in MEM feeding a branch
    MEM_MemRead = 1; MEM_rd = 5;
    ID_Branch = 1; ID_rt = 5; ID_UsesRt = 1;
    cyc(1, 0);
    ID_Branch = 0;
    cyc(0, 0);
    idle();

    // back-to-back: RUN after STALL re-evaluates immediately
    ld_br();
    cyc(1, 0);
    cyc(1, 1);
    cyc(1, 0);
    cyc(1, 1);
    idle();
    cyc(0, 0);

    // reset in the STALL cycle abandons the stall
    ld_br();
    cyc(1, 0);
    reset = 1;
    cyc(0, 0);
    reset = 0;
    idle();
    cyc(0, 0);
    EX_MemRead = 1; EX_rd = 8; ID_rs = 8;
    cyc(1, 0);
    idle();
    cyc(0, 0);

    // counter saturation on the narrow instance
    EX_MemRead = 1; EX_rd = 8; ID_rs = 8;
    for (int i = 0; i < 20; i++) cyc(1, 0);
    idle();
    IF_Flush = 1;
    for (int i = 0; i < 3; i++) cyc(0, 0);
    // flush during a stall is not counted
    EX_MemRead = 1; EX_rd = 8; ID_rs = 8;
    cyc(1, 0);
    idle();
    cyc(0, 0);
    IF_Flush = 1;
    for (int i = 0; i < 14; i++) cyc(0, 0);
    idle();
    cyc(0, 0);

    for (int i = 0; i < 4 && q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
